// File: rtl/seg595_pkg.sv
// Shared field positions, segment type and hex glyph table for the 74HC595 display snooper.
package seg595_pkg;

  localparam int unsigned FRAME_BITS_DEF = 16;
  localparam int unsigned DIGIT_BYTE_MSB = 15;
  localparam int unsigned DIGIT_BYTE_LSB = 8;
  localparam int unsigned SEG_BYTE_MSB   = 7;
  localparam int unsigned SEG_BYTE_LSB   = 0;

  typedef logic [7:0] seg_t;

  // Index n holds the a-g pattern (bit 0 = a) that displays hex digit n.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Returns {match, nibble}; {0, 0} when the pattern is not a hex glyph.
  function automatic logic [4:0] glyph_decode(input logic [6:0] i_glyph);
    logic [4:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_glyph == GLYPH_TBL[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg595_frame_rx_pin_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus a rising-edge detector.
module pin_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/seg595_frame_rx.sv
// Rebuilds latched 74HC595 display frames, decodes digit/segments and keeps a per-digit shadow.
// Define SEG595_GLYPH_DECODE_EN to enable the hex glyph decode on nibble/nibble_ok.
module seg595_frame_rx
  import seg595_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIGITS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  rclk_in,
  input  logic                  sdata_in,
  input  logic                  srclr_n_in,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] frame,
  output logic [2:0]            digit_idx,
  output logic                  digit_ok,
  output logic [7:0]            seg,
  output logic [3:0]            nibble,
  output logic                  nibble_ok,
  output logic                  len_err,
  input  logic [2:0]            rd_addr,
  output logic [7:0]            rd_seg
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DIGIT_W = DIGIT_BYTE_MSB - DIGIT_BYTE_LSB + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_sclk_sync, w_sclk_rise;
  logic w_rclk_sync, w_rclk_rise;
  logic w_sdata_sync, w_sdata_rise;
  logic w_srclr_n_sync, w_srclr_n_rise;
  logic w_unused;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .i_pin(sclk_in), .o_sync(w_sclk_sync), .o_rise_c(w_sclk_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rclk (
    .clk(clk), .rst(rst), .i_pin(rclk_in), .o_sync(w_rclk_sync), .o_rise_c(w_rclk_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdata (
    .clk(clk), .rst(rst), .i_pin(sdata_in), .o_sync(w_sdata_sync), .o_rise_c(w_sdata_rise));
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_srclr (
    .clk(clk), .rst(rst), .i_pin(srclr_n_in), .o_sync(w_srclr_n_sync), .o_rise_c(w_srclr_n_rise));

  assign w_unused = &{w_sclk_sync, w_rclk_sync, w_sdata_rise, w_srclr_n_rise};

  logic                  w_clr;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt, w_latch_val;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_eff;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_len_err;
  logic                  r_latch_d;

  assign w_clr = ~w_srclr_n_sync;

  // Clear dominates; a latch restarts the bit count, counting any shift in the same cycle.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_latch_val = w_clr ? '0 : r_shift;
    w_cnt_eff   = w_clr ? '0 : r_cnt;
    if (w_clr) begin
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      if (w_sclk_rise) begin
        w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_sdata_sync};
        if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      if (w_rclk_rise) w_cnt_nxt = w_sclk_rise ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_len_err <= 1'b0;
      r_latch_d <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_latch_d <= w_rclk_rise;
      if (w_rclk_rise) begin
        r_frame <= w_latch_val;
        if (w_cnt_eff != CNT_W'(FRAME_BITS)) r_len_err <= 1'b1;
      end
    end
  end

  // Digit lines are active low: a valid frame drives exactly one of them to zero.
  logic [DIGIT_W-1:0] w_digit_byte;
  logic [3:0]         w_zero_cnt;
  logic [2:0]         w_zero_pos;
  logic               w_one_zero;

  always_comb begin
    w_digit_byte = r_frame[DIGIT_BYTE_MSB:DIGIT_BYTE_LSB];
    w_zero_cnt   = '0;
    w_zero_pos   = '0;
    for (int i = 0; i < int'(DIGIT_W); i++) begin
      if (!w_digit_byte[i]) begin
        w_zero_cnt = w_zero_cnt + 4'd1;
        w_zero_pos = 3'(i);
      end
    end
    w_one_zero = (w_zero_cnt == 4'd1);
  end

  logic       r_fv;
  seg_t       r_seg;
  logic [2:0] r_digit_idx;
  logic       r_digit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fv        <= 1'b0;
      r_seg       <= '0;
      r_digit_idx <= '0;
      r_digit_ok  <= 1'b0;
    end else begin
      r_fv <= r_latch_d;
      if (r_latch_d) begin
        r_seg      <= seg_t'(r_frame[SEG_BYTE_MSB:SEG_BYTE_LSB]);
        r_digit_ok <= w_one_zero;
        if (w_one_zero) r_digit_idx <= w_zero_pos;
      end
    end
  end

`ifdef SEG595_GLYPH_DECODE_EN
  logic [4:0] w_glyph;
  logic [3:0] r_nibble;
  logic       r_nibble_ok;

  assign w_glyph = glyph_decode(r_frame[SEG_BYTE_LSB+6:SEG_BYTE_LSB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nibble    <= '0;
      r_nibble_ok <= 1'b0;
    end else if (r_latch_d) begin
      r_nibble    <= w_glyph[3:0];
      r_nibble_ok <= w_glyph[4];
    end
  end

  assign nibble    = r_nibble;
  assign nibble_ok = r_nibble_ok;
`else
  assign nibble    = 4'd0;
  assign nibble_ok = 1'b0;
`endif

  // Shadow of what each digit currently shows; a same-cycle read sees the old entry.
  seg_t r_shadow [DIGITS];
  seg_t r_rd_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DIGITS); i++) r_shadow[i] <= '0;
      r_rd_seg <= '0;
    end else begin
      if (r_fv && r_digit_ok) r_shadow[r_digit_idx] <= r_seg;
      r_rd_seg <= r_shadow[rd_addr];
    end
  end

  assign frame_valid = r_fv;
  assign frame       = r_frame;
  assign digit_idx   = r_digit_idx;
  assign digit_ok    = r_digit_ok;
  assign seg         = r_seg;
  assign len_err     = r_len_err;
  assign rd_seg      = r_rd_seg;

endmodule

// File: tb/tb_seg595_frame_rx.sv
// Randomized and directed bench for seg595_frame_rx against an event-level display model.
module tb_seg595_frame_rx;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_in = 1'b0, rclk_in = 1'b0, sdata_in = 1'b0, srclr_n_in = 1'b1;
  logic [2:0]  rd_addr = 3'd0;
  logic        frame_valid, digit_ok, nibble_ok, len_err;
  logic [15:0] frame;
  logic [2:0]  digit_idx;
  logic [7:0]  seg, rd_seg;
  logic [3:0]  nibble;

  seg595_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(S), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .rclk_in(rclk_in), .sdata_in(sdata_in),
    .srclr_n_in(srclr_n_in), .frame_valid(frame_valid), .frame(frame), .digit_idx(digit_idx),
    .digit_ok(digit_ok), .seg(seg), .nibble(nibble), .nibble_ok(nibble_ok), .len_err(len_err),
    .rd_addr(rd_addr), .rd_seg(rd_seg));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [6:0] tb_gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct { int due; logic [15:0] frame; logic len_err; } exp_t;
  exp_t q[$];

  bit         hist[$];
  int         m_cnt = 0;
  bit         m_len_err = 1'b0;
  logic [2:0] m_idx = 3'd0;
  logic [7:0] m_shadow [8];
  logic [7:0] exp_rd = 8'd0;
  int         force_rd = -1;
  bit         run_chk = 1'b0;
  int         last_fv_cyc = -1;
  int         lat_cyc = 0;

  function automatic logic [15:0] last16();
    logic [15:0] v;
    int n;
    v = '0;
    n = hist.size();
    for (int k = 0; k < 16; k++) if (n - 16 + k >= 0) v[15-k] = hist[n-16+k];
    return v;
  endfunction

  // Per-cycle compare against the model; also drives the shadow read address.
  initial begin
    exp_t e;
    logic [7:0] db;
    int zc, zp;
    logic ok;
    logic [3:0] enib;
    logic eok;
    forever begin
      @(negedge clk);
      if (!run_chk) continue;
      if (rst) begin
        exp_rd = 8'd0;
        continue;
      end
      chk("rd_seg", 32'(rd_seg), 32'(exp_rd));
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("frame_valid_due", 32'(frame_valid), 32'(e.due == cyc));
        if (frame_valid) last_fv_cyc = cyc;
        db = e.frame[15:8];
        zc = 0; zp = 0;
        for (int i = 0; i < 8; i++) if (!db[i]) begin zc++; zp = i; end
        ok = (zc == 1);
        if (ok) m_idx = 3'(zp);
        enib = 4'd0; eok = 1'b0;
`ifdef SEG595_GLYPH_DECODE_EN
        for (int g = 0; g < 16; g++) if (e.frame[6:0] == tb_gl[g]) begin enib = 4'(g); eok = 1'b1; end
`endif
        chk("frame", 32'(frame), 32'(e.frame));
        chk("seg", 32'(seg), 32'(e.frame[7:0]));
        chk("digit_ok", 32'(digit_ok), 32'(ok));
        chk("digit_idx", 32'(digit_idx), 32'(m_idx));
        chk("nibble", 32'(nibble), 32'(enib));
        chk("nibble_ok", 32'(nibble_ok), 32'(eok));
        chk("len_err", 32'(len_err), 32'(e.len_err));
        rd_addr = (force_rd >= 0) ? 3'(force_rd) : 3'($urandom_range(0, 7));
        exp_rd = m_shadow[rd_addr];
        if (ok) m_shadow[m_idx] = e.frame[7:0];
      end else begin
        chk("frame_valid_idle", 32'(frame_valid), 32'd0);
        rd_addr = (force_rd >= 0) ? 3'(force_rd) : 3'($urandom_range(0, 7));
        exp_rd = m_shadow[rd_addr];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic shift_bit(input bit b);
    sdata_in = b;
    tick(2);
    sclk_in = 1'b1;
    hist.push_back(b);
    if (m_cnt < 31) m_cnt++;
    tick(2);
    sclk_in = 1'b0;
  endtask

  task automatic latch();
    rclk_in = 1'b1;
    lat_cyc = cyc;
    if (m_cnt != 16) m_len_err = 1'b1;
    q.push_back('{due: cyc + S + 2, frame: last16(), len_err: m_len_err});
    m_cnt = 0;
    tick(2);
    rclk_in = 1'b0;
    tick(2);
  endtask

  task automatic latch_with_shift(input bit b);
    sdata_in = b;
    tick(2);
    sclk_in = 1'b1;
    rclk_in = 1'b1;
    lat_cyc = cyc;
    if (m_cnt != 16) m_len_err = 1'b1;
    q.push_back('{due: cyc + S + 2, frame: last16(), len_err: m_len_err});
    hist.push_back(b);
    m_cnt = 1;
    tick(2);
    sclk_in = 1'b0;
    rclk_in = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [15:0] f);
    for (int i = 15; i >= 0; i--) shift_bit(f[i]);
    latch();
  endtask

  task automatic clear_sr();
    srclr_n_in = 1'b0;
    hist.delete();
    m_cnt = 0;
    tick(3);
    srclr_n_in = 1'b1;
    tick(2);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick(1);
    chk("drain_pending", 32'(q.size()), 32'd0);
    tick(2);
  endtask

  task automatic chk_reset();
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_digit_idx", 32'(digit_idx), 32'd0);
    chk("rst_digit_ok", 32'(digit_ok), 32'd0);
    chk("rst_nibble", 32'(nibble), 32'd0);
    chk("rst_nibble_ok", 32'(nibble_ok), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_rd_seg", 32'(rd_seg), 32'd0);
  endtask

  task automatic do_reset();
    wait_idle();
    rst = 1'b1;
    hist.delete();
    m_cnt = 0;
    m_len_err = 1'b0;
    m_idx = 3'd0;
    for (int i = 0; i < 8; i++) m_shadow[i] = 8'd0;
    tick(2);
    chk_reset();
    rst = 1'b0;
    tick(4);
  endtask

  task automatic read_shadow(input int a, input logic [7:0] exp, input string name);
    force_rd = a;
    tick(3);
    chk(name, 32'(rd_seg), 32'(exp));
    force_rd = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] db, sb;
    for (int i = 0; i < 8; i++) m_shadow[i] = 8'd0;
    tick(3);
    chk_reset();
    rst = 1'b0;
    run_chk = 1'b1;
    tick(4);

    // Single frame for digit 4 showing '5'.
    send_frame(16'hEF6D);
    tick(S + 4);
    chk("t1_latency", 32'(last_fv_cyc - lat_cyc), 32'(S + 2));
    chk("t1_digit_idx", 32'(digit_idx), 32'd4);
    chk("t1_digit_ok", 32'(digit_ok), 32'd1);
    chk("t1_seg", 32'(seg), 32'h6D);
`ifdef SEG595_GLYPH_DECODE_EN
    chk("t1_nibble", 32'(nibble), 32'd5);
    chk("t1_nibble_ok", 32'(nibble_ok), 32'd1);
`else
    chk("t1_nibble", 32'(nibble), 32'd0);
    chk("t1_nibble_ok", 32'(nibble_ok), 32'd0);
`endif
    chk("t1_len_err", 32'(len_err), 32'd0);
    read_shadow(4, 8'h6D, "t1_rd_seg");

    // Digits 0-7 showing glyphs 0-7.
    for (int d = 0; d < 8; d++) begin
      db = ~(8'h01 << d);
      send_frame({db, 1'b0, tb_gl[d]});
    end
    wait_idle();
    for (int d = 0; d < 8; d++) read_shadow(d, {1'b0, tb_gl[d]}, "t2_shadow");

    // Blank and multi-select digit bytes must leave the shadow alone.
    send_frame(16'hFF7F);
    wait_idle();
    chk("t3_ff_digit_ok", 32'(digit_ok), 32'd0);
    chk("t3_ff_digit_idx", 32'(digit_idx), 32'd7);
    send_frame(16'hEE7F);
    wait_idle();
    chk("t3_ee_digit_ok", 32'(digit_ok), 32'd0);
    for (int d = 0; d < 8; d++) read_shadow(d, {1'b0, tb_gl[d]}, "t3_shadow");

    // Shift and latch in the same cycle: latch sees pre-shift content, count restarts at 1.
    for (int i = 15; i >= 0; i--) shift_bit(1'(16'h7F4F >> i));
    latch_with_shift(1'b1);
    wait_idle();
    chk("t4_pre_shift_frame", 32'(frame), 32'h7F4F);
    for (int i = 14; i >= 0; i--) shift_bit(1'(16'hFD66 >> i));
    latch();
    wait_idle();
    chk("t4_next_frame", 32'(frame), 32'hFD66);
    chk("t4_len_err", 32'(len_err), 32'd0);

    // Shift-register clear in mid-frame discards the earlier bits.
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    clear_sr();
    send_frame(16'hFB5B);
    wait_idle();
    chk("t5_clr_frame", 32'(frame), 32'hFB5B);
    chk("t5_clr_len_err", 32'(len_err), 32'd0);

    // Reset in mid-frame, then a clean frame.
    for (int i = 0; i < 7; i++) shift_bit(1'b1);
    do_reset();
    send_frame(16'hDF06);
    wait_idle();
    chk("t6_rst_frame", 32'(frame), 32'hDF06);
    chk("t6_rst_len_err", 32'(len_err), 32'd0);
    chk("t6_rst_digit_idx", 32'(digit_idx), 32'd5);

    // Randomized frames, some preceded by junk bits and a clear.
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) db = ~(8'h01 << $urandom_range(0, 7));
      else if (r < 85) db = 8'hFF;
      else db = 8'($urandom);
      if ($urandom_range(0, 99) < 60) sb = {1'($urandom), tb_gl[$urandom_range(0, 15)]};
      else sb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 10)); i++) shift_bit(1'($urandom));
        clear_sr();
      end
      send_frame({db, sb});
    end
    wait_idle();

    // Short frame sets the sticky length error; good frames do not clear it.
    for (int i = 0; i < 12; i++) shift_bit(1'($urandom));
    latch();
    wait_idle();
    chk("t7_len_err_set", 32'(len_err), 32'd1);
    send_frame(16'hBF7D);
    send_frame(16'h7F07);
    wait_idle();
    chk("t7_len_err_sticky", 32'(len_err), 32'd1);
    do_reset();
    chk("t7_len_err_cleared", 32'(len_err), 32'd0);
    send_frame(16'hFE3F);
    wait_idle();
    chk("t7_after_rst_len_err", 32'(len_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
